// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranger and the blocks
// that use the same 1 us tick.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_e;

    localparam int DEF_TRIG_US         = 10;
    localparam int DEF_ECHO_TIMEOUT_US = 30000;
    localparam int DEF_PERIOD_US       = 60000;
    localparam int DEF_US_PER_CM       = 58;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_DIST_W          = 10;

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins, request controls and distance result of the ranger.
// The slave side is the ranger itself; the master side is its user.
interface ultrasonic_ranger_if
    import ultrasonic_pkg::*;
#(
    parameter int DIST_W = DEF_DIST_W
);
    logic              start;
    logic              auto_en;
    logic              echo;
    logic              trig;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    modport master (
        output start, auto_en, echo,
        input  trig, distance, dist_valid, timeout, busy
    );

    modport slave (
        input  start, auto_en, echo,
        output trig, distance, dist_valid, timeout, busy
    );
endinterface

// File: rtl/tick_gen.sv
// Turns the free-running 1 MHz divided clock into a one-cycle tick on the
// system clock. The divided clock is treated as asynchronous data.
module tick_gen (
    input  logic clk_in,
    input  logic rst,
    input  logic clk_1m_i,
    output logic tick_o
);
    logic q1_q;
    logic q2_q;
    logic q3_q;

    // Two-flop synchroniser followed by one delay flop for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
            q3_q <= 1'b0;
        end else begin
            q1_q <= clk_1m_i;
            q2_q <= q1_q;
            q3_q <= q2_q;
        end
    end

    assign tick_o = q2_q & ~q3_q;
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style measurement controller: fires the trigger pulse, times the
// echo in 1 us ticks and converts it to centimetres with a running
// divide-by-US_PER_CM, publishing the result with a one-cycle strobe.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int TRIG_US         = DEF_TRIG_US,
    parameter int ECHO_TIMEOUT_US = DEF_ECHO_TIMEOUT_US,
    parameter int PERIOD_US       = DEF_PERIOD_US,
    parameter int US_PER_CM       = DEF_US_PER_CM,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DIST_W          = DEF_DIST_W
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 clk_1m,
    ultrasonic_ranger_if.slave   bus
);
    // Counter compare points: each fires on the tick that completes the interval.
    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_US - 1);
    localparam logic [CNT_W-1:0] SUB_LAST    = CNT_W'(US_PER_CM - 1);

    logic              tick;
    logic              echo_m_q;
    logic              echo_s_q;
    logic              echo_p_q;
    logic              echo_rise;
    logic              echo_fall;

    state_e            state_q;
    logic              trig_q;
    logic [DIST_W-1:0] distance_q;
    logic              dist_valid_q;
    logic              timeout_q;
    logic              busy_q;
    logic [CNT_W-1:0]  us_cnt_q;
    logic [CNT_W-1:0]  period_cnt_q;
    logic [CNT_W-1:0]  sub_cnt_q;
    logic [DIST_W-1:0] cm_cnt_q;

    // Centimetre count sticks at full scale instead of wrapping.
    function automatic logic [DIST_W-1:0] cm_sat_inc(input logic [DIST_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    tick_gen u_tick_gen (
        .clk_in   (clk_in),
        .rst      (rst),
        .clk_1m_i (clk_1m),
        .tick_o   (tick)
    );

    // Echo synchroniser plus previous-sample flop for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            echo_m_q <= 1'b0;
            echo_s_q <= 1'b0;
            echo_p_q <= 1'b0;
        end else begin
            echo_m_q <= bus.echo;
            echo_s_q <= echo_m_q;
            echo_p_q <= echo_s_q;
        end
    end

    // Edges only: an echo already high when WAIT_ECHO is entered never counts as a rise.
    assign echo_rise =  echo_s_q & ~echo_p_q;
    assign echo_fall = ~echo_s_q &  echo_p_q;

    // Measurement sequencer with registered pin and result outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            trig_q       <= 1'b0;
            distance_q   <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            us_cnt_q     <= '0;
            period_cnt_q <= '0;
            sub_cnt_q    <= '0;
            cm_cnt_q     <= '0;
        end else begin
            dist_valid_q <= 1'b0;
            if (tick) begin
                us_cnt_q <= us_cnt_q + 1'b1;
                if (period_cnt_q != '1) begin
                    period_cnt_q <= period_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start || bus.auto_en) begin
                        state_q      <= TRIG;
                        trig_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        us_cnt_q     <= '0;
                        period_cnt_q <= '0;
                    end
                end

                TRIG: begin
                    if (tick && us_cnt_q >= TRIG_LAST) begin
                        state_q  <= WAIT_ECHO;
                        trig_q   <= 1'b0;
                        us_cnt_q <= '0;
                    end
                end

                WAIT_ECHO: begin
                    if (echo_rise) begin
                        state_q   <= MEASURE;
                        us_cnt_q  <= '0;
                        sub_cnt_q <= '0;
                        cm_cnt_q  <= '0;
                    end else if (tick && us_cnt_q >= ECHO_LAST) begin
                        state_q   <= HOLDOFF;
                        timeout_q <= 1'b1;
                        us_cnt_q  <= '0;
                    end
                end

                MEASURE: begin
                    // The fall is checked first so a fall coinciding with the timeout still reports.
                    if (echo_fall) begin
                        state_q      <= HOLDOFF;
                        distance_q   <= cm_cnt_q;
                        dist_valid_q <= 1'b1;
                        timeout_q    <= 1'b0;
                        us_cnt_q     <= '0;
                    end else if (tick && us_cnt_q >= ECHO_LAST) begin
                        state_q   <= HOLDOFF;
                        timeout_q <= 1'b1;
                        us_cnt_q  <= '0;
                    end else if (tick) begin
                        if (sub_cnt_q >= SUB_LAST) begin
                            sub_cnt_q <= '0;
                            cm_cnt_q  <= cm_sat_inc(cm_cnt_q);
                        end else begin
                            sub_cnt_q <= sub_cnt_q + 1'b1;
                        end
                    end
                end

                HOLDOFF: begin
                    if (!bus.auto_en) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        us_cnt_q <= '0;
                    end else if (tick && period_cnt_q >= PERIOD_LAST) begin
                        // Trigger rising edges land exactly PERIOD_US ticks apart.
                        state_q      <= TRIG;
                        trig_q       <= 1'b1;
                        us_cnt_q     <= '0;
                        period_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    trig_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    us_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.trig       = trig_q;
    assign bus.distance   = distance_q;
    assign bus.dist_valid = dist_valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for the ultrasonic ranger with scaled-down timing so a full
// auto-repeat sequence fits in a short run.
module tb_ultrasonic_ranger;
    localparam int TRIG_US         = 10;
    localparam int ECHO_TIMEOUT_US = 700;
    localparam int PERIOD_US       = 1400;
    localparam int US_PER_CM       = 5;
    localparam int CNT_W           = 16;
    localparam int DIST_W          = 7;
    localparam int TICK_CYC        = 4;

    localparam int SIG_TRIG = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_TO   = 2;
    localparam int SIG_VLD  = 3;

    logic clk_in = 1'b0;
    logic clk_1m = 1'b0;
    logic rst    = 1'b1;

    ultrasonic_ranger_if #(.DIST_W(DIST_W)) u_if ();

    ultrasonic_ranger #(
        .TRIG_US         (TRIG_US),
        .ECHO_TIMEOUT_US (ECHO_TIMEOUT_US),
        .PERIOD_US       (PERIOD_US),
        .US_PER_CM       (US_PER_CM),
        .CNT_W           (CNT_W),
        .DIST_W          (DIST_W)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_1m (clk_1m),
        .bus    (u_if.slave)
    );

    always #5  clk_in = ~clk_in;
    always #20 clk_1m = ~clk_1m;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int rise_cyc[$];
    logic trig_prev = 1'b0;

    always @(negedge clk_in) begin
        cyc++;
        if (u_if.dist_valid === 1'b1) vld_cnt++;
        if (u_if.trig === 1'b1 && trig_prev !== 1'b1) rise_cyc.push_back(cyc);
        trig_prev = u_if.trig;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            SIG_TRIG: return u_if.trig;
            SIG_BUSY: return u_if.busy;
            SIG_TO:   return u_if.timeout;
            default:  return u_if.dist_valid;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input logic val,
                            input int budget, output int cycles);
        cycles = 0;
        while (get_sig(which) !== val && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
        end
        check({"bound_", tag}, 32'(get_sig(which) === val), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        u_if.start = 1'b1;
        @(negedge clk_in);
        u_if.start = 1'b0;
    endtask

    task automatic echo_pulse(input int delay_ticks, input int echo_ticks);
        repeat (delay_ticks) @(negedge clk_1m);
        u_if.echo = 1'b1;
        repeat (echo_ticks) @(negedge clk_1m);
        u_if.echo = 1'b0;
    endtask

    task automatic run_meas(input string tag, input int delay_ticks, input int echo_ticks,
                            input bit double_start, output int trig_w);
        int c;
        pulse_start();
        wait_for({tag, "_trig_hi"}, SIG_TRIG, 1'b1, 20, c);
        if (double_start) pulse_start();
        wait_for({tag, "_trig_lo"}, SIG_TRIG, 1'b0, 100, trig_w);
        if (echo_ticks > 0) echo_pulse(delay_ticks, echo_ticks);
        wait_for({tag, "_idle"}, SIG_BUSY, 1'b0, 4000, c);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, w, v0, r0, sp;
        u_if.start   = 1'b0;
        u_if.auto_en = 1'b0;
        u_if.echo    = 1'b0;
        rst          = 1'b1;
        repeat (5) @(negedge clk_in);
        check("rst_trig",  32'(u_if.trig), 32'd0);
        check("rst_dist",  32'(u_if.distance), 32'd0);
        check("rst_vld",   32'(u_if.dist_valid), 32'd0);
        check("rst_to",    32'(u_if.timeout), 32'd0);
        check("rst_busy",  32'(u_if.busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        // 500 ticks of echo -> 100 cm
        v0 = vld_cnt;
        run_meas("m100", 20, 500, 1'b0, w);
        check("m100_trig_w", 32'(w >= (TRIG_US - 1) * TICK_CYC && w <= (TRIG_US + 1) * TICK_CYC), 32'd1);
        check("m100_dist", 32'(u_if.distance), 32'd100);
        check("m100_vld",  32'(vld_cnt - v0), 32'd1);
        check("m100_to",   32'(u_if.timeout), 32'd0);
        check("m100_busy", 32'(u_if.busy), 32'd0);

        // Just below and exactly one centimetre
        v0 = vld_cnt;
        run_meas("m4", 20, 4, 1'b0, w);
        check("m4_dist", 32'(u_if.distance), 32'd0);
        check("m4_vld",  32'(vld_cnt - v0), 32'd1);
        v0 = vld_cnt;
        run_meas("m5", 20, 5, 1'b0, w);
        check("m5_dist", 32'(u_if.distance), 32'd1);
        check("m5_vld",  32'(vld_cnt - v0), 32'd1);

        // 650 ticks -> 130 cm, saturates at 127
        v0 = vld_cnt;
        run_meas("msat", 20, 650, 1'b0, w);
        check("msat_dist", 32'(u_if.distance), 32'd127);
        check("msat_vld",  32'(vld_cnt - v0), 32'd1);
        check("msat_to",   32'(u_if.timeout), 32'd0);

        // Echo never rises: timeout exactly ECHO_TIMEOUT_US ticks after trig falls
        v0 = vld_cnt;
        pulse_start();
        wait_for("nr_trig_hi", SIG_TRIG, 1'b1, 20, c);
        wait_for("nr_trig_lo", SIG_TRIG, 1'b0, 100, c);
        wait_for("nr_to", SIG_TO, 1'b1, 3000, c);
        check("nr_to_cyc", 32'(c), 32'(ECHO_TIMEOUT_US * TICK_CYC));
        wait_for("nr_idle", SIG_BUSY, 1'b0, 4, c);
        check("nr_dist", 32'(u_if.distance), 32'd127);
        check("nr_vld",  32'(vld_cnt - v0), 32'd0);
        check("nr_to_v", 32'(u_if.timeout), 32'd1);

        // Echo stuck high past the timeout
        v0 = vld_cnt;
        run_meas("stk", 20, 900, 1'b0, w);
        check("stk_to",   32'(u_if.timeout), 32'd1);
        check("stk_vld",  32'(vld_cnt - v0), 32'd0);
        check("stk_dist", 32'(u_if.distance), 32'd127);

        // Echo already high on entry is ignored; only the later rise counts (50 ticks -> 10 cm)
        v0 = vld_cnt;
        u_if.echo = 1'b1;
        pulse_start();
        wait_for("pre_trig_hi", SIG_TRIG, 1'b1, 20, c);
        wait_for("pre_trig_lo", SIG_TRIG, 1'b0, 100, c);
        repeat (20) @(negedge clk_1m);
        u_if.echo = 1'b0;
        echo_pulse(20, 50);
        wait_for("pre_idle", SIG_BUSY, 1'b0, 4000, c);
        check("pre_dist", 32'(u_if.distance), 32'd10);
        check("pre_vld",  32'(vld_cnt - v0), 32'd1);
        check("pre_to",   32'(u_if.timeout), 32'd0);

        // Auto repeat: 100 ticks of echo -> 20 cm, trig rises PERIOD_US ticks apart
        v0 = vld_cnt;
        r0 = rise_cyc.size();
        u_if.auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_for("auto_hi", SIG_TRIG, 1'b1, 6000, c);
            wait_for("auto_lo", SIG_TRIG, 1'b0, 100, c);
            if (k == 3) u_if.auto_en = 1'b0;
            echo_pulse(20, 100);
            wait_for("auto_vld", SIG_VLD, 1'b1, 20, c);
            check("auto_dist", 32'(u_if.distance), 32'd20);
        end
        wait_for("auto_idle", SIG_BUSY, 1'b0, 20, c);
        check("auto_nvld",  32'(vld_cnt - v0), 32'd4);
        check("auto_nrise", 32'(rise_cyc.size() - r0), 32'd4);
        if (rise_cyc.size() >= r0 + 4) begin
            sp = rise_cyc[r0 + 1] - rise_cyc[r0];
            check("auto_sp1", 32'(sp > (PERIOD_US - 1) * TICK_CYC && sp <= PERIOD_US * TICK_CYC), 32'd1);
            check("auto_sp2", 32'(rise_cyc[r0 + 2] - rise_cyc[r0 + 1]), 32'(PERIOD_US * TICK_CYC));
            check("auto_sp3", 32'(rise_cyc[r0 + 3] - rise_cyc[r0 + 2]), 32'(PERIOD_US * TICK_CYC));
        end
        repeat (100) @(negedge clk_1m);
        check("auto_stop_rise", 32'(rise_cyc.size() - r0), 32'd4);
        check("auto_stop_busy", 32'(u_if.busy), 32'd0);

        // Reset in the middle of MEASURE
        pulse_start();
        wait_for("rm_trig_hi", SIG_TRIG, 1'b1, 20, c);
        wait_for("rm_trig_lo", SIG_TRIG, 1'b0, 100, c);
        repeat (20) @(negedge clk_1m);
        u_if.echo = 1'b1;
        repeat (50) @(negedge clk_1m);
        @(negedge clk_in);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("rm_dist", 32'(u_if.distance), 32'd0);
        check("rm_busy", 32'(u_if.busy), 32'd0);
        check("rm_trig", 32'(u_if.trig), 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        u_if.echo = 1'b0;
        v0 = vld_cnt;
        repeat (10) @(negedge clk_1m);
        check("rm_no_vld",  32'(vld_cnt - v0), 32'd0);
        check("rm_idle",    32'(u_if.busy), 32'd0);

        // Reset while trig is high drops it on the same edge
        pulse_start();
        wait_for("rt_trig_hi", SIG_TRIG, 1'b1, 20, c);
        @(negedge clk_in);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("rt_trig", 32'(u_if.trig), 32'd0);
        check("rt_busy", 32'(u_if.busy), 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        // Second start during TRIG is neither honoured nor queued
        v0 = vld_cnt;
        r0 = rise_cyc.size();
        run_meas("dbl", 20, 100, 1'b1, w);
        check("dbl_dist",  32'(u_if.distance), 32'd20);
        check("dbl_vld",   32'(vld_cnt - v0), 32'd1);
        repeat (50) @(negedge clk_1m);
        check("dbl_nrise", 32'(rise_cyc.size() - r0), 32'd1);
        check("dbl_busy",  32'(u_if.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Measurement controller for an HC-SR04-style ultrasonic sensor.
- Consumes the 1 MHz divided clock as a data signal, edge-detects it, and uses each rising edge as a 1 us tick. All logic runs on the single system clock.
- Issues the trigger pulse, times the echo pulse in microseconds and converts the echo width to centimetres with a running divide-by-58.
- Publishes the distance with a one-cycle valid strobe to the downstream distance/obstacle logic.

Parameters:
- TRIG_US, 10, width of the trigger pulse in us ticks
- ECHO_TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo width, in us ticks
- PERIOD_US, 60000, minimum spacing between trigger rising edges in auto mode, in us ticks
- US_PER_CM, 58, us ticks per centimetre of distance
- CNT_W, 16, width of the internal us counter; must hold PERIOD_US
- DIST_W, 10, width of the distance output in cm

Ports:
- clk_in, in, 1, system clock (50 MHz)
- rst, in, 1, synchronous reset, active-high
- clk_1m, in, 1, 1 MHz divided clock, sampled as data
- echo, in, 1, sensor echo pin, asynchronous
- start, in, 1, single-cycle request for one measurement
- auto_en, in, 1, when high, measurements repeat every PERIOD_US
- trig, out, 1, sensor trigger pin
- distance, out, DIST_W, last measured distance in cm; held between measurements
- dist_valid, out, 1, one-cycle strobe when distance updates
- timeout, out, 1, sticky flag for the last measurement; high if it failed
- busy, out, 1, high in every state except IDLE

Behaviour:
- Reset values (all synchronous on rst=1):
  - trig=0, distance=0, dist_valid=0, timeout=0, busy=0
  - state=IDLE, all counters 0, synchroniser flops 0
- Tick generation:
  - clk_1m passes through two flops, then a third flop for edge detection.
  - tick = q2 & ~q3, giving exactly one clk_in cycle per 1 us.
- Echo synchronisation: echo passes through a two-flop synchroniser. echo_s is the synchronised value; the echo rise/fall is echo_s compared with its previous sample.
- The us counter (us_cnt) increments on tick only. It clears on every state entry.
- States and transitions:
  - IDLE: leave when start=1 or auto_en=1. Go to TRIG, set trig=1, and clear period_cnt.
  - TRIG: trig=1 until us_cnt reaches TRIG_US on a tick. Then trig=0 and go to WAIT_ECHO.
  - WAIT_ECHO: echo_s rise → MEASURE, clearing cm_cnt and sub_cnt. If us_cnt reaches ECHO_TIMEOUT_US first → set timeout=1, distance unchanged, go to HOLDOFF.
  - MEASURE:
    - On each tick, sub_cnt increments. When sub_cnt reaches US_PER_CM-1, sub_cnt clears and cm_cnt increments.
    - cm_cnt saturates at 2^DIST_W-1.
    - echo_s fall → distance<=cm_cnt, dist_valid=1 for one cycle, timeout<=0, go to HOLDOFF.
    - If us_cnt reaches ECHO_TIMEOUT_US while echo is still high → timeout=1, no dist_valid, go to HOLDOFF.
  - HOLDOFF:
    - period_cnt counts ticks from the entry to TRIG.
    - When auto_en=1 and period_cnt ≥ PERIOD_US-1 → TRIG.
    - When auto_en=0 → IDLE immediately.
- Rounding: distance = floor(echo_us / US_PER_CM), with echo_us counted in whole ticks.
- Boundary conditions:
  - start while busy is ignored and is not queued.
  - A simultaneous echo fall and timeout in the same cycle: the fall wins and the result is valid.
  - An echo that is already high on entry to WAIT_ECHO is not a rise. Wait for low, then high.
  - If clk_1m stops, the FSM stalls. There is no clk_in-based watchdog.
  - rst mid-measurement: trig drops in the same edge and distance clears to 0.
  - Dropping auto_en mid-measurement finishes the current measurement, then goes to IDLE.

Decomposition:
- Shared package (ultrasonic_pkg):
  - state enum: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF
  - default timing constants: 10, 30000, 60000, 58
- Sub-module tick_gen: synchroniser plus rising-edge detector. Input clk_1m, output a one-cycle tick. It is reused by other 1 us-timed blocks (servo, buzzer).

Test Plan:
- Pulse start, then echo high 5800 us starting 200 us after trig falls → trig high for 10 ticks (±1 tick for sync), dist_valid once, distance=100, timeout=0.
- Echo high 57 us → distance=0, dist_valid=1. Echo high 58 us → distance=1.
- Echo never rises → timeout=1 at 30000 ticks after trig falls, no dist_valid, distance keeps its prior value, busy falls.
- Echo stuck high for 40000 us → timeout=1 at 30000 ticks, no dist_valid.
- auto_en=1 with echo 1160 us each cycle → trig rising edges exactly 60000 ticks apart, distance=20 each time. Drop auto_en → returns to IDLE after the current measurement.
- Assert rst during MEASURE → same edge: trig=0, distance=0, busy=0, state IDLE. Pulse start pulsed twice within TRIG → only one measurement.
